// File: rtl/control_sequencer_pkg.sv
// Shared control-line encodings, opcode constants and halt causes for the
// multicycle control sequencer.
package control_sequencer_pkg;

    localparam int unsigned OPCODE_WIDTH = 7;
    localparam int unsigned FUNCT3_WIDTH = 3;

    // Major opcodes, bits [6:2] of the instruction opcode field
    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    localparam logic [2:0] FUNCT3_WORD = 3'b010;

    typedef enum logic [1:0] {
        MEM_NOP           = 2'd0,
        MEM_LOAD          = 2'd1,
        MEM_STORE_PRELOAD = 2'd2,
        MEM_STORE         = 2'd3
    } MemoryMode_t;

    typedef enum logic [4:0] {
        RD_ALU         = 5'b00001,
        RD_IMMEDIATE   = 5'b00010,
        RD_PC_PLUS_IMM = 5'b00100,
        RD_NEXT_PC     = 5'b01000,
        RD_MEMORY      = 5'b10000
    } RDSourceSelectLines_t;

    typedef enum logic {
        ADDR_CURRENT_PC = 1'b0,
        ADDR_NEXT_PC    = 1'b1
    } InstructionAddressSource_t;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'd0,
        ALU_OP_IMM = 2'd1,
        ALU_OP     = 2'd2
    } AluMode_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } ImmediateFormerMode_t;

    typedef enum logic [2:0] {
        BR_EQ   = 3'b000,
        BR_NE   = 3'b001,
        BR_NONE = 3'b010,
        BR_JUMP = 3'b011,
        BR_LT   = 3'b100,
        BR_GE   = 3'b101,
        BR_LTU  = 3'b110,
        BR_GEU  = 3'b111
    } BranchALUMode_t;

    typedef enum logic [2:0] {
        HALT_NONE          = 3'd0,
        HALT_ECALL         = 3'd1,
        HALT_PC_MISALIGNED = 3'd2,
        HALT_MEM_UNALIGNED = 3'd3,
        HALT_TIMEOUT       = 3'd4,
        HALT_BAD_OPCODE    = 3'd5
    } HaltCause_t;

    // Conditional-branch comparison; reserved funct3 values compare nothing
    function automatic BranchALUMode_t branch_mode(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return BR_EQ;
            3'b001:  return BR_NE;
            3'b100:  return BR_LT;
            3'b101:  return BR_GE;
            3'b110:  return BR_LTU;
            3'b111:  return BR_GEU;
            default: return BR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_counters.sv
// Debug cycle/retired counters plus the memory wait-state watchdog counter.
module control_sequencer_counters
    import control_sequencer_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = 32,
    parameter int unsigned WAIT_TIMEOUT  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cycle_en,
    input  logic                     instret_en,
    input  logic                     wait_clear,
    input  logic                     wait_en,
    output logic [COUNTER_WIDTH-1:0] cycle_count,
    output logic [COUNTER_WIDTH-1:0] instret_count,
    output logic                     timeout_c
);

    // The watchdog fires on the wait cycle that would make the count reach WAIT_TIMEOUT
    localparam int unsigned WAIT_WIDTH = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT);
    localparam logic [WAIT_WIDTH-1:0] WAIT_LAST =
        WAIT_WIDTH'((WAIT_TIMEOUT == 0) ? 0 : WAIT_TIMEOUT - 1);

    logic [WAIT_WIDTH-1:0] wait_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count   <= '0;
            instret_count <= '0;
            wait_count    <= '0;
        end else begin
            if (cycle_en)   cycle_count   <= cycle_count + COUNTER_WIDTH'(1);
            if (instret_en) instret_count <= instret_count + COUNTER_WIDTH'(1);
            if (wait_clear)   wait_count <= '0;
            else if (wait_en) wait_count <= wait_count + WAIT_WIDTH'(1);
        end
    end

    assign timeout_c = (WAIT_TIMEOUT != 0) && wait_en && (wait_count == WAIT_LAST);

endmodule

// File: rtl/control_sequencer.sv
// Multicycle control sequencer: decodes opcode/funct3 into datapath controls,
// stalls memory ops on memReady, and halts on errors, ecall or illegal opcodes.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH   = 32,
    parameter int unsigned WAIT_TIMEOUT    = 16,
    parameter int unsigned SW_SINGLE_CYCLE = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [OPCODE_WIDTH-1:0]     opcode,
    input  logic [FUNCT3_WIDTH-1:0]     funct3,
    input  logic                        memReady,
    input  logic                        programCounterMisaligned,
    input  logic                        memoryUnalignedAccess,
    output logic                        rdWriteEnable,
    output MemoryMode_t                 memoryMode,
    output RDSourceSelectLines_t        rdSourceSelectLines,
    output logic                        programCounterWriteEnable,
    output InstructionAddressSource_t   instructionAddressSource,
    output AluMode_t                    aluMode,
    output ImmediateFormerMode_t        immediateFormerMode,
    output BranchALUMode_t              branchALUMode,
    output logic                        halted,
    output HaltCause_t                  haltCause,
    output logic [COUNTER_WIDTH-1:0]    cycleCount,
    output logic [COUNTER_WIDTH-1:0]    instretCount
);

    typedef enum logic [1:0] {
        INITIAL_FETCH = 2'd0,
        FETCH_EXECUTE = 2'd1,
        MEM_ACCESS    = 2'd2,
        HALT          = 2'd3
    } State_t;

    State_t     state, next_state;
    logic       mem_done;
    logic       advance, hit_ecall, hit_bad_opcode;
    logic       error_c, store_single_c, is_store_c, wait_en_c, wait_timeout_c;
    HaltCause_t halt_cause_c;
    logic       unused_opcode_bits;

    assign unused_opcode_bits = ^opcode[1:0];
    assign error_c        = programCounterMisaligned || memoryUnalignedAccess;
    assign is_store_c     = (opcode[6:2] == OPC_STORE);
    assign store_single_c = (SW_SINGLE_CYCLE != 0) && (funct3 == FUNCT3_WORD);
    assign wait_en_c      = (state == MEM_ACCESS) && !memReady;
    assign halted         = (state == HALT);

    // mem_done marks the FETCH_EXECUTE cycle that completes a held memory instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INITIAL_FETCH;
            mem_done  <= 1'b0;
            haltCause <= HALT_NONE;
        end else begin
            state    <= next_state;
            mem_done <= (state == MEM_ACCESS) && (next_state == FETCH_EXECUTE);
            if (state != HALT && next_state == HALT) haltCause <= halt_cause_c;
        end
    end

    always_comb begin
        next_state          = state;
        advance             = 1'b0;
        hit_ecall           = 1'b0;
        hit_bad_opcode      = 1'b0;
        rdWriteEnable       = 1'b0;
        memoryMode          = MEM_NOP;
        rdSourceSelectLines = RD_ALU;
        aluMode             = ALU_ADD;
        immediateFormerMode = IMM_I;
        branchALUMode       = BR_NONE;

        case (state)
            INITIAL_FETCH: next_state = FETCH_EXECUTE;
            FETCH_EXECUTE: begin
                case (opcode[6:2])
                    OPC_LUI: begin
                        rdWriteEnable = 1'b1; rdSourceSelectLines = RD_IMMEDIATE;
                        immediateFormerMode = IMM_U; advance = 1'b1;
                    end
                    OPC_AUIPC: begin
                        rdWriteEnable = 1'b1; rdSourceSelectLines = RD_PC_PLUS_IMM;
                        immediateFormerMode = IMM_U; advance = 1'b1;
                    end
                    OPC_JAL: begin
                        rdWriteEnable = 1'b1; rdSourceSelectLines = RD_NEXT_PC;
                        immediateFormerMode = IMM_J; branchALUMode = BR_JUMP; advance = 1'b1;
                    end
                    OPC_JALR: begin
                        rdWriteEnable = 1'b1; rdSourceSelectLines = RD_NEXT_PC;
                        branchALUMode = BR_JUMP; advance = 1'b1;
                    end
                    OPC_BRANCH: begin
                        immediateFormerMode = IMM_B; branchALUMode = branch_mode(funct3);
                        advance = 1'b1;
                    end
                    OPC_OP_IMM: begin
                        rdWriteEnable = 1'b1; aluMode = ALU_OP_IMM; advance = 1'b1;
                    end
                    OPC_OP: begin
                        rdWriteEnable = 1'b1; aluMode = ALU_OP; advance = 1'b1;
                    end
                    OPC_MISC_MEM: advance = 1'b1;
                    OPC_LOAD: begin
                        if (mem_done) begin
                            rdWriteEnable = 1'b1; rdSourceSelectLines = RD_MEMORY;
                            memoryMode = MEM_LOAD; advance = 1'b1;
                        end else begin
                            next_state = MEM_ACCESS;
                        end
                    end
                    OPC_STORE: begin
                        immediateFormerMode = IMM_S;
                        if (mem_done || store_single_c) begin
                            memoryMode = MEM_STORE; advance = 1'b1;
                        end else begin
                            next_state = MEM_ACCESS;
                        end
                    end
                    OPC_SYSTEM: begin
                        hit_ecall = 1'b1; next_state = HALT;
                    end
                    default: begin
                        hit_bad_opcode = 1'b1; next_state = HALT;
                    end
                endcase
            end
            MEM_ACCESS: begin
                immediateFormerMode = is_store_c ? IMM_S : IMM_I;
                memoryMode = is_store_c ? MEM_STORE_PRELOAD : MEM_LOAD;
                if (memReady)            next_state = FETCH_EXECUTE;
                else if (wait_timeout_c) next_state = HALT;
            end
            HALT: next_state = HALT;
            default: next_state = HALT;
        endcase

        // Error flags pre-empt everything, including any write this cycle
        if (state != HALT && error_c) begin
            next_state    = HALT;
            advance       = 1'b0;
            rdWriteEnable = 1'b0;
            memoryMode    = MEM_NOP;
        end
    end

    assign programCounterWriteEnable = advance;
    assign instructionAddressSource  = advance ? ADDR_NEXT_PC : ADDR_CURRENT_PC;

    always_comb begin
        halt_cause_c = HALT_NONE;
        if (programCounterMisaligned)   halt_cause_c = HALT_PC_MISALIGNED;
        else if (memoryUnalignedAccess) halt_cause_c = HALT_MEM_UNALIGNED;
        else if (wait_timeout_c)        halt_cause_c = HALT_TIMEOUT;
        else if (hit_bad_opcode)        halt_cause_c = HALT_BAD_OPCODE;
        else if (hit_ecall)             halt_cause_c = HALT_ECALL;
    end

    control_sequencer_counters #(
        .COUNTER_WIDTH (COUNTER_WIDTH),
        .WAIT_TIMEOUT  (WAIT_TIMEOUT)
    ) u_counters (
        .clk           (clk),
        .rst_n         (rst_n),
        .cycle_en      (state != HALT),
        .instret_en    (programCounterWriteEnable),
        .wait_clear    (state != MEM_ACCESS),
        .wait_en       (wait_en_c),
        .cycle_count   (cycleCount),
        .instret_count (instretCount),
        .timeout_c     (wait_timeout_c)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench: dut_a uses a 4-cycle watchdog and single-cycle sw,
// dut_b disables the watchdog and preloads every store; both use 8-bit counters.
module tb_control_sequencer;
    import control_sequencer_pkg::*;

    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_ECALL = 7'b1110011;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       memReady, pcm, mua;

    logic                      a_rdwe, a_pcwe, a_halted;
    MemoryMode_t               a_mem;
    RDSourceSelectLines_t      a_src;
    InstructionAddressSource_t a_addr;
    AluMode_t                  a_alu;
    ImmediateFormerMode_t      a_imm;
    BranchALUMode_t            a_br;
    HaltCause_t                a_cause;
    logic [7:0]                a_cycle, a_instret;

    logic                      b_rdwe, b_pcwe, b_halted;
    MemoryMode_t               b_mem;
    RDSourceSelectLines_t      b_src;
    InstructionAddressSource_t b_addr;
    AluMode_t                  b_alu;
    ImmediateFormerMode_t      b_imm;
    BranchALUMode_t            b_br;
    HaltCause_t                b_cause;
    logic [7:0]                b_cycle, b_instret;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    control_sequencer #(.COUNTER_WIDTH(8), .WAIT_TIMEOUT(4), .SW_SINGLE_CYCLE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .memReady(memReady),
        .programCounterMisaligned(pcm), .memoryUnalignedAccess(mua),
        .rdWriteEnable(a_rdwe), .memoryMode(a_mem), .rdSourceSelectLines(a_src),
        .programCounterWriteEnable(a_pcwe), .instructionAddressSource(a_addr),
        .aluMode(a_alu), .immediateFormerMode(a_imm), .branchALUMode(a_br),
        .halted(a_halted), .haltCause(a_cause), .cycleCount(a_cycle), .instretCount(a_instret)
    );

    control_sequencer #(.COUNTER_WIDTH(8), .WAIT_TIMEOUT(0), .SW_SINGLE_CYCLE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .memReady(memReady),
        .programCounterMisaligned(pcm), .memoryUnalignedAccess(mua),
        .rdWriteEnable(b_rdwe), .memoryMode(b_mem), .rdSourceSelectLines(b_src),
        .programCounterWriteEnable(b_pcwe), .instructionAddressSource(b_addr),
        .aluMode(b_alu), .immediateFormerMode(b_imm), .branchALUMode(b_br),
        .halted(b_halted), .haltCause(b_cause), .cycleCount(b_cycle), .instretCount(b_instret)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset; on return the DUTs are in their first INITIAL_FETCH cycle
    task automatic restart(input logic [6:0] op, input logic [2:0] f3, input logic rdy);
        rst_n = 1'b0; opcode = op; funct3 = f3; memReady = rdy; pcm = 1'b0; mua = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0; opcode = OP_ADDI; funct3 = 3'b000; memReady = 1'b0; pcm = 1'b0; mua = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_halted",  32'(a_halted),  32'd0);
        check("rst_cause",   32'(a_cause),   32'(HALT_NONE));
        check("rst_cycle",   32'(a_cycle),   32'd0);
        check("rst_instret", 32'(a_instret), 32'd0);
        check("rst_memmode", 32'(a_mem),     32'(MEM_NOP));
        check("rst_pcwe",    32'(a_pcwe),    32'd0);
        rst_n = 1'b1;
        #1;
        check("if_pcwe", 32'(a_pcwe), 32'd0);
        check("if_addr", 32'(a_addr), 32'(ADDR_CURRENT_PC));

        // addi stream: one retirement per cycle after the initial fetch
        cyc();
        check("addi_pcwe", 32'(a_pcwe), 32'd1);
        check("addi_rdwe", 32'(a_rdwe), 32'd1);
        check("addi_src",  32'(a_src),  32'(RD_ALU));
        check("addi_addr", 32'(a_addr), 32'(ADDR_NEXT_PC));
        check("addi_alu",  32'(a_alu),  32'(ALU_OP_IMM));
        repeat (10) cyc();
        check("addi_instret", 32'(a_instret), 32'd10);
        check("addi_cycle",   32'(a_cycle),   32'd11);

        // lw, memReady low for 3 MEM_ACCESS cycles, high on the 4th (watchdog boundary)
        restart(OP_LW, 3'b010, 1'b0);
        cyc();
        check("lw_fe_mem",  32'(a_mem),  32'(MEM_NOP));
        check("lw_fe_pcwe", 32'(a_pcwe), 32'd0);
        check("lw_fe_rdwe", 32'(a_rdwe), 32'd0);
        cyc();
        check("lw_ma_mem",  32'(a_mem),  32'(MEM_LOAD));
        check("lw_ma_addr", 32'(a_addr), 32'(ADDR_CURRENT_PC));
        cyc(); cyc(); cyc();
        memReady = 1'b1; #1;
        check("lw_ma4_halted", 32'(a_halted), 32'd0);
        check("lw_ma4_mem",    32'(a_mem),    32'(MEM_LOAD));
        cyc();
        memReady = 1'b0; #1;
        check("lw_done_rdwe", 32'(a_rdwe), 32'd1);
        check("lw_done_src",  32'(a_src),  32'(RD_MEMORY));
        check("lw_done_mem",  32'(a_mem),  32'(MEM_LOAD));
        check("lw_done_pcwe", 32'(a_pcwe), 32'd1);
        cyc();
        check("lw_after_rdwe", 32'(a_rdwe),    32'd0);
        check("lw_instret",    32'(a_instret), 32'd1);
        check("lw_cycle",      32'(a_cycle),   32'd7);
        check("lw_halted",     32'(a_halted),  32'd0);

        // Watchdog expiry with memReady held low
        restart(OP_LW, 3'b010, 1'b0);
        cyc();
        cyc(); cyc(); cyc(); cyc();
        check("to_pre_halted", 32'(a_halted), 32'd0);
        cyc();
        check("to_halted",   32'(a_halted), 32'd1);
        check("to_cause",    32'(a_cause),  32'(HALT_TIMEOUT));
        check("to_cycle",    32'(a_cycle),  32'd6);
        check("to_mem",      32'(a_mem),    32'(MEM_NOP));
        check("to_b_halted", 32'(b_halted), 32'd0);
        check("to_b_mem",    32'(b_mem),    32'(MEM_LOAD));
        repeat (3) cyc();
        check("to_cycle_frozen", 32'(a_cycle), 32'd6);
        check("to_cause_held",   32'(a_cause), 32'(HALT_TIMEOUT));

        // sw: single cycle on dut_a, preload then store on dut_b
        restart(OP_SW, 3'b010, 1'b1);
        cyc();
        check("sw_a_mem",  32'(a_mem),  32'(MEM_STORE));
        check("sw_a_pcwe", 32'(a_pcwe), 32'd1);
        check("sw_a_rdwe", 32'(a_rdwe), 32'd0);
        check("sw_b_mem",  32'(b_mem),  32'(MEM_NOP));
        check("sw_b_pcwe", 32'(b_pcwe), 32'd0);
        cyc();
        check("sw_b_pre_mem",  32'(b_mem),  32'(MEM_STORE_PRELOAD));
        check("sw_b_pre_pcwe", 32'(b_pcwe), 32'd0);
        cyc();
        check("sw_b_st_mem",  32'(b_mem),  32'(MEM_STORE));
        check("sw_b_st_pcwe", 32'(b_pcwe), 32'd1);
        funct3 = 3'b000; #1;
        check("sb_a_fe_mem", 32'(a_mem), 32'(MEM_NOP));
        cyc();
        check("sb_a_pre_mem", 32'(a_mem), 32'(MEM_STORE_PRELOAD));

        // ecall with unaligned access: the error wins
        restart(OP_ADDI, 3'b000, 1'b0);
        cyc();
        opcode = OP_ECALL; mua = 1'b1; #1;
        check("err_pcwe", 32'(a_pcwe), 32'd0);
        check("err_rdwe", 32'(a_rdwe), 32'd0);
        cyc();
        check("err_halted", 32'(a_halted), 32'd1);
        check("err_cause",  32'(a_cause),  32'(HALT_MEM_UNALIGNED));

        restart(OP_ECALL, 3'b000, 1'b0);
        cyc();
        check("ecall_pcwe", 32'(a_pcwe), 32'd0);
        cyc();
        check("ecall_cause", 32'(a_cause), 32'(HALT_ECALL));

        restart(OP_BAD, 3'b000, 1'b0);
        cyc();
        check("bad_rdwe", 32'(a_rdwe), 32'd0);
        check("bad_pcwe", 32'(a_pcwe), 32'd0);
        cyc();
        check("bad_halted", 32'(a_halted), 32'd1);
        check("bad_cause",  32'(a_cause),  32'(HALT_BAD_OPCODE));
        pcm = 1'b1;
        cyc();
        check("bad_cause_kept", 32'(a_cause), 32'(HALT_BAD_OPCODE));

        restart(OP_ADDI, 3'b000, 1'b0);
        pcm = 1'b1; mua = 1'b1;
        cyc();
        check("pcm_halted", 32'(a_halted), 32'd1);
        check("pcm_cause",  32'(a_cause),  32'(HALT_PC_MISALIGNED));

        // Reset asserted in the middle of a store preload
        restart(OP_SW, 3'b000, 1'b0);
        cyc();
        cyc();
        check("rma_pre_mem", 32'(a_mem), 32'(MEM_STORE_PRELOAD));
        rst_n = 1'b0; #1;
        check("rma_mem",     32'(a_mem),     32'(MEM_NOP));
        check("rma_pcwe",    32'(a_pcwe),    32'd0);
        check("rma_halted",  32'(a_halted),  32'd0);
        check("rma_cycle",   32'(a_cycle),   32'd0);
        check("rma_instret", 32'(a_instret), 32'd0);
        memReady = 1'b1;
        rst_n = 1'b1; #1;
        check("rma_if_mem", 32'(a_mem), 32'(MEM_NOP));
        cyc();
        check("rma_fe_mem", 32'(a_mem), 32'(MEM_NOP));

        // 8-bit counters wrap
        restart(OP_ADDI, 3'b000, 1'b0);
        repeat (255) cyc();
        check("wrap_cycle_255",   32'(a_cycle),   32'd255);
        check("wrap_instret_254", 32'(a_instret), 32'd254);
        cyc();
        check("wrap_cycle_0",     32'(a_cycle),   32'd0);
        check("wrap_instret_255", 32'(a_instret), 32'd255);
        cyc();
        check("wrap_cycle_1",     32'(a_cycle),   32'd1);
        check("wrap_instret_0",   32'(a_instret), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
